// File: rtl/urv_divider_iter.sv
// -----------------------------------------------------------------------------
// urv_divider_iter
//   Iterative restoring divider for the RISC-V M-extension divide group
//   (DIV, DIVU, REM, REMU). The operand magnitudes are divided unsigned.
//   The sign is applied in a single fix-up cycle at the end. Divide-by-zero
//   and signed overflow either take a one-cycle bypass (EARLY_OUT=1) or fall
//   out of the normal datapath with the architecturally required results.
//
// Parameters
//   XLEN           operand/result width (8..64, multiple of BITS_PER_CYCLE)
//   BITS_PER_CYCLE quotient bits resolved per BUSY cycle (1, 2 or 4)
//   EARLY_OUT      1: bypass iteration for divide-by-zero / signed overflow
//
// Ports
//   clk_i          clock, all state on rising edge
//   rst_n_i        asynchronous active-low reset
//   x_stall_i      execute stage held (keeps DONE alive)
//   x_kill_i       execute instruction squashed (aborts BUSY/FIXUP)
//   x_stall_req_o  divider requests pipeline stall (combinational)
//   d_valid_i      decode instruction valid
//   d_is_divide_i  instruction belongs to the divide group
//   d_fun_i        funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   d_rs1_i        dividend
//   d_rs2_i        divisor
//   x_rd_o         result
//   x_done_o       x_rd_o valid for the held instruction
// -----------------------------------------------------------------------------
module urv_divider_iter #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int EARLY_OUT      = 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            x_stall_i,
  input  logic            x_kill_i,
  output logic            x_stall_req_o,
  input  logic            d_valid_i,
  input  logic            d_is_divide_i,
  input  logic [2:0]      d_fun_i,
  input  logic [XLEN-1:0] d_rs1_i,
  input  logic [XLEN-1:0] d_rs2_i,
  output logic [XLEN-1:0] x_rd_o,
  output logic            x_done_o
);

  localparam int N_STEPS = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W   = $clog2(N_STEPS + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;     // partial remainder
  logic [XLEN-1:0]   quo_q, quo_d;     // dividend shifting out, quotient shifting in
  logic [XLEN-1:0]   dvs_q, dvs_d;     // divisor magnitude
  logic [XLEN-1:0]   rd_q, rd_d;
  logic              neg_q, neg_d;     // result must be negated in FIXUP
  logic              is_rem_q, is_rem_d;

  // ---------------------------------------------------------------------------
  // Operand decode (valid in the start cycle only)
  // ---------------------------------------------------------------------------
  logic            op_signed, op_rem;
  logic            rs1_neg, rs2_neg;
  logic            rs2_zero, sgn_ovf, special, start;
  logic [XLEN-1:0] rs1_mag, rs2_mag, early_rd;

  assign op_signed = ~d_fun_i[0];
  assign op_rem    = d_fun_i[1];
  assign rs1_neg   = op_signed & d_rs1_i[XLEN-1];
  assign rs2_neg   = op_signed & d_rs2_i[XLEN-1];
  // Two's complement of MIN_NEG is MIN_NEG itself, which is exactly the
  // correct unsigned magnitude, so no extra bit is needed here.
  assign rs1_mag   = rs1_neg ? ({XLEN{1'b0}} - d_rs1_i) : d_rs1_i;
  assign rs2_mag   = rs2_neg ? ({XLEN{1'b0}} - d_rs2_i) : d_rs2_i;
  assign rs2_zero  = (d_rs2_i == {XLEN{1'b0}});
  assign sgn_ovf   = op_signed & (d_rs1_i == MIN_NEG) & (d_rs2_i == {XLEN{1'b1}});
  assign special   = rs2_zero | sgn_ovf;
  assign early_rd  = rs2_zero ? (op_rem ? d_rs1_i : {XLEN{1'b1}})
                              : (op_rem ? {XLEN{1'b0}} : d_rs1_i);

  // funct3[2] is set for every divide-group encoding; requiring it keeps a
  // malformed decode from launching an operation. Gating with rst_n_i keeps
  // the stall request low while reset is held.
  assign start = rst_n_i & (state_q == S_IDLE) & d_valid_i & d_is_divide_i
               & d_fun_i[2] & ~x_kill_i;

  // ---------------------------------------------------------------------------
  // Restoring shift-subtract chain, BITS_PER_CYCLE stages per clock.
  // The subtraction is XLEN+1 bits wide: the shifted remainder is below
  // 2*divisor, so the difference always fits and its MSB is a clean borrow.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] step_rem [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] step_quo [BITS_PER_CYCLE+1];

  assign step_rem[0] = rem_q;
  assign step_quo[0] = quo_q;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted          = {step_rem[gi], step_quo[gi][XLEN-1]};
    assign diff             = shifted - {1'b0, dvs_q};
    assign step_rem[gi + 1] = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign step_quo[gi + 1] = {step_quo[gi][XLEN-2:0], ~diff[XLEN]};
  end

  // With a zero divisor every stage "succeeds", leaving an all-ones quotient
  // magnitude and the dividend magnitude as remainder; neg_q is cleared for
  // the quotient in that case so the all-ones pattern survives FIXUP.
  logic [XLEN-1:0] fix_mag, fix_rd;

  assign fix_mag = is_rem_q ? rem_q : quo_q;
  assign fix_rd  = neg_q ? ({XLEN{1'b0}} - fix_mag) : fix_mag;

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    rd_d          = rd_q;
    neg_d         = neg_q;
    is_rem_d      = is_rem_q;
    x_stall_req_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_stall_req_o = 1'b1;
          is_rem_d      = op_rem;
          neg_d         = op_rem ? rs1_neg : ((rs1_neg ^ rs2_neg) & ~rs2_zero);
          if ((EARLY_OUT != 0) && special) begin
            rd_d    = early_rd;
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            rem_d   = {XLEN{1'b0}};
            quo_d   = rs1_mag;
            dvs_d   = rs2_mag;
            cnt_d   = CNT_W'(N_STEPS);
            state_d = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        x_stall_req_o = 1'b1;
        if (x_kill_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem[BITS_PER_CYCLE];
          quo_d = step_quo[BITS_PER_CYCLE];
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_FIXUP;
          end
        end
      end

      S_FIXUP: begin
        x_stall_req_o = 1'b1;
        if (x_kill_i) begin
          state_d = S_IDLE;
        end else begin
          rd_d    = fix_rd;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // Leaving DONE never re-launches: the next start is only evaluated
        // once the state register reads IDLE.
        if (!x_stall_i || x_kill_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      is_rem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      is_rem_q <= is_rem_d;
    end
  end

  assign x_rd_o   = rd_q;
  assign x_done_o = (state_q == S_DONE);

endmodule
